// File: rtl/dsi_rx_frame_ctrl_if.sv
// Pixel output stream of the serial receive frame sequencer.
// Carries RGB data, the valid/ready handshake and the sof/eol/eof sideband flags.
interface dsi_rx_frame_ctrl_if;
   logic [23:0] pixel_data;
   logic        pixel_valid;
   logic        pixel_ready;
   logic        sof;
   logic        eol;
   logic        eof;

   modport master (
      output pixel_data,
      output pixel_valid,
      output sof,
      output eol,
      output eof,
      input  pixel_ready
   );

   modport slave (
      input  pixel_data,
      input  pixel_valid,
      input  sof,
      input  eol,
      input  eof,
      output pixel_ready
   );
endinterface

// File: rtl/dsi_rx_frame_ctrl.sv
// Frame/line sequencer: hunts for the sync word, assembles 24-bit pixels,
// tracks line/frame position and hands pixels out through a 2-entry buffer.
module dsi_rx_frame_ctrl #(
   parameter int          H_ACTIVE  = 640,
   parameter int          V_ACTIVE  = 480,
   parameter logic [23:0] SYNC_WORD = 24'hFF00A5
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       serial_data,
   input  logic                       bit_en,
   input  logic                       clr_err,
   dsi_rx_frame_ctrl_if.master        pix,
   output logic                       frame_active,
   output logic                       sync_err,
   output logic                       overflow
);

   localparam int PW = $clog2(H_ACTIVE + 1);
   localparam int LW = $clog2(V_ACTIVE + 1);
   localparam logic [PW-1:0] LAST_PIX  = PW'(H_ACTIVE - 1);
   localparam logic [LW-1:0] LAST_LINE = LW'(V_ACTIVE - 1);

   typedef enum logic [1:0] {
      HUNT,
      LINE,
      LSYNC
   } state_t;

   state_t        state;
   // Only 23 history bits are kept; the incoming bit completes the 24-bit word.
   logic [22:0]   shift_reg;
   logic [4:0]    bit_cnt;
   logic [PW-1:0] pix_cnt;
   logic [LW-1:0] line_cnt;

   logic [23:0]   word;
   logic          word_done;
   logic          pix_done;
   logic          sync_hit;
   logic          last_pix;
   logic          last_line;

   assign word      = {shift_reg, serial_data};
   assign word_done = bit_en && (bit_cnt == 5'd23);
   assign pix_done  = word_done && (state == LINE);
   assign sync_hit  = (word == SYNC_WORD);
   assign last_pix  = (pix_cnt == LAST_PIX);
   assign last_line = (line_cnt == LAST_LINE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= HUNT;
         shift_reg    <= '0;
         bit_cnt      <= '0;
         pix_cnt      <= '0;
         line_cnt     <= '0;
         frame_active <= 1'b0;
         sync_err     <= 1'b0;
      end else begin
         sync_err <= 1'b0;
         if (bit_en) begin
            shift_reg <= word[22:0];
            case (state)
               HUNT: begin
                  if (sync_hit) begin
                     state        <= LINE;
                     frame_active <= 1'b1;
                     bit_cnt      <= '0;
                     pix_cnt      <= '0;
                     line_cnt     <= '0;
                  end
               end
               LINE: begin
                  if (bit_cnt == 5'd23) begin
                     bit_cnt <= '0;
                     pix_cnt <= pix_cnt + 1'b1;
                     if (last_pix) begin
                        if (last_line) begin
                           state        <= HUNT;
                           frame_active <= 1'b0;
                        end else begin
                           state <= LSYNC;
                        end
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 5'd1;
                  end
               end
               LSYNC: begin
                  if (bit_cnt == 5'd23) begin
                     bit_cnt <= '0;
                     if (sync_hit) begin
                        state    <= LINE;
                        line_cnt <= line_cnt + 1'b1;
                        pix_cnt  <= '0;
                     end else begin
                        state        <= HUNT;
                        frame_active <= 1'b0;
                        sync_err     <= 1'b1;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 5'd1;
                  end
               end
               default: begin
                  state        <= HUNT;
                  frame_active <= 1'b0;
               end
            endcase
         end
      end
   end

   // Buffer entries are {eof, eol, sof, pixel}; the head is presented directly.
   logic [26:0] fifo_mem [2];
   logic [26:0] head;
   logic [26:0] push_entry;
   logic        wr_ptr;
   logic        rd_ptr;
   logic [1:0]  fifo_cnt;
   logic        pop;
   logic        accept;
   logic        drop;

   assign push_entry = {last_pix && last_line, last_pix,
                        (pix_cnt == '0) && (line_cnt == '0), word};
   assign head       = fifo_mem[rd_ptr];
   assign pop        = pix.pixel_valid && pix.pixel_ready;
   assign accept     = pix_done && ((fifo_cnt != 2'd2) || pop);
   assign drop       = pix_done && (fifo_cnt == 2'd2) && !pop;

   assign pix.pixel_valid = (fifo_cnt != 2'd0);
   assign pix.pixel_data  = head[23:0];
   assign pix.sof         = head[24];
   assign pix.eol         = head[25];
   assign pix.eof         = head[26];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_mem[0] <= '0;
         fifo_mem[1] <= '0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         fifo_cnt    <= 2'd0;
         overflow    <= 1'b0;
      end else begin
         if (accept) begin
            fifo_mem[wr_ptr] <= push_entry;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({accept, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
            2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
            default: fifo_cnt <= fifo_cnt;
         endcase
         // A drop in the same cycle as a clear leaves the flag set.
         if (drop) begin
            overflow <= 1'b1;
         end else if (clr_err) begin
            overflow <= 1'b0;
         end
      end
   end

endmodule
